// File: rtl/alu_op_issuer.sv
// Initiator for a combinational ALU: accepts one command, holds ain/bin/ctrl for a settle
// latency, captures result and flags, and returns them over a valid/ready response port.
module alu_op_issuer #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_ain,
    output logic [WIDTH-1:0] alu_bin,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int LAT_EFF = (ALU_LAT < 1) ? 1 : ALU_LAT;
    localparam int LAT_W   = $clog2(LAT_EFF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [LAT_W-1:0]   lat_cnt_q,   lat_cnt_d;
    logic [WIDTH-1:0]   ain_q,       ain_d;
    logic [WIDTH-1:0]   bin_q,       bin_d;
    logic [3:0]         ctrl_q,      ctrl_d;
    logic [WIDTH-1:0]   data_q,      data_d;
    logic [2:0]         flags_q,     flags_d;
    logic               err_q,       err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q,      busy_d;
    logic [CNT_W-1:0]   op_count_q,  op_count_d;

    logic cmd_fire;
    logic cmd_bad;

    assign cmd_fire = (state_q == IDLE) && cmd_ready_q && cmd_valid;
    // Illegal opcodes and divide/modulo by zero never reach the ALU.
    assign cmd_bad  = (cmd_op > 4'b1100) ||
                      (((cmd_op == 4'b0011) || (cmd_op == 4'b0100)) && (cmd_b == '0));

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        ain_d      = ain_q;
        bin_d      = bin_q;
        ctrl_d     = ctrl_q;
        data_d     = data_q;
        flags_d    = flags_q;
        err_d      = err_q;
        op_count_d = op_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        data_d  = '0;
                        flags_d = 3'b000;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        ain_d     = cmd_a;
                        bin_d     = cmd_b;
                        ctrl_d    = cmd_op;
                        lat_cnt_d = LAT_W'(LAT_EFF);
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == LAT_W'(1)) begin
                    lat_cnt_d = '0;
                    data_d    = alu_out;
                    flags_d   = {alu_v, alu_n, alu_z};
                    err_d     = 1'b0;
                    state_d   = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next state.
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            ain_q       <= '0;
            bin_q       <= '0;
            ctrl_q      <= '0;
            data_q      <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            ain_q       <= ain_d;
            bin_q       <= bin_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_ain   = ain_q;
    assign alu_bin   = bin_q;
    assign alu_ctrl  = ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = data_q;
    assign rsp_flags = flags_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: a 1-cycle-latency, 2-bit-counter instance and a
// 4-cycle-latency instance, each driving a small combinational ALU model.
module tb_alu_op_issuer;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Instance A: ALU_LAT=1, CNT_W=2
    logic          rst_a, cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_ready_a, rsp_err_a, busy_a;
    logic [3:0]    cmd_op_a, alu_ctrl_a;
    logic [W-1:0]  cmd_a_a, cmd_b_a, alu_ain_a, alu_bin_a, alu_out_a, rsp_data_a;
    logic          alu_z_a, alu_n_a, alu_v_a;
    logic [2:0]    rsp_flags_a;
    logic [1:0]    op_count_a;

    // Instance B: ALU_LAT=4, CNT_W=16
    logic          rst_b, cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b, busy_b;
    logic [3:0]    cmd_op_b, alu_ctrl_b;
    logic [W-1:0]  cmd_a_b, cmd_b_b, alu_ain_b, alu_bin_b, alu_out_b, rsp_data_b;
    logic          alu_z_b, alu_n_b, alu_v_b;
    logic [2:0]    rsp_flags_b;
    logic [15:0]   op_count_b;

    alu_op_issuer #(.WIDTH(W), .ALU_LAT(1), .CNT_W(2)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op_a),
        .cmd_a(cmd_a_a), .cmd_b(cmd_b_a),
        .alu_ain(alu_ain_a), .alu_bin(alu_bin_a), .alu_ctrl(alu_ctrl_a),
        .alu_out(alu_out_a), .alu_z(alu_z_a), .alu_n(alu_n_a), .alu_v(alu_v_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a),
        .rsp_flags(rsp_flags_a), .rsp_err(rsp_err_a), .busy(busy_a), .op_count(op_count_a)
    );

    alu_op_issuer #(.WIDTH(W), .ALU_LAT(4), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op_b),
        .cmd_a(cmd_a_b), .cmd_b(cmd_b_b),
        .alu_ain(alu_ain_b), .alu_bin(alu_bin_b), .alu_ctrl(alu_ctrl_b),
        .alu_out(alu_out_b), .alu_z(alu_z_b), .alu_n(alu_n_b), .alu_v(alu_v_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
        .rsp_flags(rsp_flags_b), .rsp_err(rsp_err_b), .busy(busy_b), .op_count(op_count_b)
    );

    // Returns {v, n, z, result}
    function automatic logic [W+2:0] alu_model(input logic [3:0] ctrl,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         v;
        r = '0;
        v = 1'b0;
        case (ctrl)
            4'd0:  begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'd1:  begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'd2:  r = a * b;
            4'd3:  r = (b != '0) ? a / b : '0;
            4'd4:  r = (b != '0) ? a % b : '0;
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = ~a;
            4'd11: r = {{(W-1){1'b0}}, (a < b)};
            4'd12: r = {{(W-1){1'b0}}, ((a != '0) || (b != '0))};
            default: r = '0;
        endcase
        return {v, r[W-1], (r == '0), r};
    endfunction

    assign {alu_v_a, alu_n_a, alu_z_a, alu_out_a} = alu_model(alu_ctrl_a, alu_ain_a, alu_bin_a);
    assign {alu_v_b, alu_n_b, alu_z_b, alu_out_b} = alu_model(alu_ctrl_b, alu_ain_b, alu_bin_b);

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_data;
        logic [2:0]   exp_flags;
        logic         exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        int guard;
        guard = 0;
        while (!cmd_ready_a && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("cmd_ready_a_before_issue", 64'(cmd_ready_a), 64'd1);
        cmd_valid_a = 1'b1;
        cmd_op_a    = op;
        cmd_a_a     = a;
        cmd_b_a     = b;
        @(negedge clk);
        cmd_valid_a = 1'b0;
    endtask

    task automatic waitRspA(output int lat);
        lat = 1;
        while (!rsp_valid_a && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           lat;
        logic [1:0]   exp_cnt_a;
        logic [W-1:0] last_ain, last_bin;
        logic [3:0]   last_ctrl;
        logic         seen_valid;

        vecs[0]  = '{4'b0000, 32'd5,          32'd7, 32'd12,         3'b000, 1'b0};
        vecs[1]  = '{4'b0011, 32'd9,          32'd0, 32'd0,          3'b000, 1'b1};
        vecs[2]  = '{4'b1110, 32'd1,          32'd2, 32'd0,          3'b000, 1'b1};
        vecs[3]  = '{4'b0001, 32'd2,          32'd5, 32'hFFFF_FFFD,  3'b010, 1'b0};
        vecs[4]  = '{4'b0000, 32'h7FFF_FFFF,  32'd1, 32'h8000_0000,  3'b110, 1'b0};
        vecs[5]  = '{4'b0100, 32'd10,         32'd3, 32'd1,          3'b000, 1'b0};
        vecs[6]  = '{4'b0011, 32'd20,         32'd4, 32'd5,          3'b000, 1'b0};
        vecs[7]  = '{4'b0100, 32'd7,          32'd0, 32'd0,          3'b000, 1'b1};
        vecs[8]  = '{4'b1101, 32'd3,          32'd4, 32'd0,          3'b000, 1'b1};
        vecs[9]  = '{4'b1100, 32'd0,          32'd0, 32'd0,          3'b001, 1'b0};
        vecs[10] = '{4'b1111, 32'd0,          32'd1, 32'd0,          3'b000, 1'b1};
        vecs[11] = '{4'b0011, 32'd0,          32'd5, 32'd0,          3'b001, 1'b0};

        rst_a = 1'b1; cmd_valid_a = 1'b0; cmd_op_a = '0; cmd_a_a = '0; cmd_b_a = '0; rsp_ready_a = 1'b0;
        rst_b = 1'b1; cmd_valid_b = 1'b0; cmd_op_b = '0; cmd_a_b = '0; cmd_b_b = '0; rsp_ready_b = 1'b0;
        exp_cnt_a = 2'd0;
        last_ain  = '0;
        last_bin  = '0;
        last_ctrl = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ctl_a", {cmd_ready_a, rsp_valid_a, busy_a, rsp_err_a, rsp_flags_a,
                                    alu_ctrl_a, op_count_a}, 64'd0);
        checkOutput("reset_alu_a", {alu_ain_a, alu_bin_a}, 64'd0);
        checkOutput("reset_data_a", 64'(rsp_data_a), 64'd0);
        checkOutput("reset_ctl_b", {cmd_ready_b, rsp_valid_b, busy_b, rsp_err_b, rsp_flags_b,
                                    alu_ctrl_b, op_count_b}, 64'd0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        checkOutput("cmd_ready_a_at_release", 64'(cmd_ready_a), 64'd0);
        @(negedge clk);
        checkOutput("cmd_ready_a_after_release", 64'(cmd_ready_a), 64'd1);
        checkOutput("cmd_ready_b_after_release", 64'(cmd_ready_b), 64'd1);
        checkOutput("busy_a_idle", 64'(busy_a), 64'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitRspA(lat);
            checkOutput($sformatf("v%0d_latency", i), 64'(lat), vecs[i].exp_err ? 64'd1 : 64'd2);
            checkOutput($sformatf("v%0d_data", i), 64'(rsp_data_a), 64'(vecs[i].exp_data));
            checkOutput($sformatf("v%0d_flags", i), 64'(rsp_flags_a), 64'(vecs[i].exp_flags));
            checkOutput($sformatf("v%0d_err", i), 64'(rsp_err_a), 64'(vecs[i].exp_err));
            checkOutput($sformatf("v%0d_busy", i), 64'(busy_a), 64'd1);
            if (!vecs[i].exp_err) begin
                last_ain  = vecs[i].a;
                last_bin  = vecs[i].b;
                last_ctrl = vecs[i].op;
            end
            checkOutput($sformatf("v%0d_alu_ab", i), {alu_ain_a, alu_bin_a}, {last_ain, last_bin});
            checkOutput($sformatf("v%0d_alu_ctrl", i), 64'(alu_ctrl_a), 64'(last_ctrl));
            rsp_ready_a = 1'b1;
            @(negedge clk);
            rsp_ready_a = 1'b0;
            exp_cnt_a = exp_cnt_a + 2'd1;
            checkOutput($sformatf("v%0d_rsp_valid_drop", i), 64'(rsp_valid_a), 64'd0);
            checkOutput($sformatf("v%0d_op_count", i), 64'(op_count_a), 64'(exp_cnt_a));
            checkOutput($sformatf("v%0d_idle_gap", i), 64'(cmd_ready_a), 64'd1);
        end

        // Backpressure: response held for 5 cycles while a competing command is ignored.
        applyStimulus(4'b0001, 32'd3, 32'd3);
        waitRspA(lat);
        checkOutput("bp_latency", 64'(lat), 64'd2);
        cmd_valid_a = 1'b1;
        cmd_op_a    = 4'b0000;
        cmd_a_a     = 32'd100;
        cmd_b_a     = 32'd200;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp%0d_valid", k), 64'(rsp_valid_a), 64'd1);
            checkOutput($sformatf("bp%0d_data", k), 64'(rsp_data_a), 64'd0);
            checkOutput($sformatf("bp%0d_flags", k), 64'(rsp_flags_a), 64'b001);
            checkOutput($sformatf("bp%0d_cmd_ready", k), 64'(cmd_ready_a), 64'd0);
            checkOutput($sformatf("bp%0d_alu", k), {alu_ctrl_a, alu_ain_a}, {4'b0001, 32'd3});
            @(negedge clk);
        end
        cmd_valid_a = 1'b0;
        rsp_ready_a = 1'b1;
        @(negedge clk);
        rsp_ready_a = 1'b0;
        exp_cnt_a = exp_cnt_a + 2'd1;
        checkOutput("bp_valid_drop", 64'(rsp_valid_a), 64'd0);
        checkOutput("bp_op_count", 64'(op_count_a), 64'(exp_cnt_a));

        // Reset during WAIT on the 4-cycle instance abandons the command.
        cmd_valid_b = 1'b1;
        cmd_op_b    = 4'b0000;
        cmd_a_b     = 32'd1;
        cmd_b_b     = 32'd2;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        checkOutput("b_wait_busy", 64'(busy_b), 64'd1);
        checkOutput("b_wait_alu", {alu_ain_b, alu_bin_b}, {32'd1, 32'd2});
        @(negedge clk);
        @(negedge clk);
        checkOutput("b_wait_no_valid", 64'(rsp_valid_b), 64'd0);
        rst_b = 1'b1;
        #1;
        checkOutput("b_rst_ctl", {cmd_ready_b, rsp_valid_b, busy_b, rsp_err_b, rsp_flags_b,
                                  alu_ctrl_b, op_count_b}, 64'd0);
        checkOutput("b_rst_alu", {alu_ain_b, alu_bin_b}, 64'd0);
        seen_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            seen_valid = seen_valid | rsp_valid_b;
        end
        rst_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen_valid = seen_valid | rsp_valid_b;
        end
        checkOutput("b_no_rsp_after_abort", 64'(seen_valid), 64'd0);
        checkOutput("b_cmd_ready_after_abort", 64'(cmd_ready_b), 64'd1);

        cmd_valid_b = 1'b1;
        cmd_op_b    = 4'b0000;
        cmd_a_b     = 32'd4;
        cmd_b_b     = 32'd5;
        @(negedge clk);
        cmd_valid_b = 1'b0;
        lat = 1;
        while (!rsp_valid_b && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b_latency", 64'(lat), 64'd5);
        checkOutput("b_data", 64'(rsp_data_b), 64'd9);
        checkOutput("b_flags_err", {rsp_flags_b, rsp_err_b}, 64'd0);
        rsp_ready_b = 1'b1;
        @(negedge clk);
        rsp_ready_b = 1'b0;
        checkOutput("b_valid_drop", 64'(rsp_valid_b), 64'd0);
        checkOutput("b_op_count", 64'(op_count_b), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
